// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles the instruction-memory request channel and the IF/ID handoff
//   channel of the fetch sequencer.
//   master : sequencer side (drives imem_req/imem_addr, if_valid/if_instr/if_pc)
//   slave  : memory + IF/ID side (drives imem_ack/imem_rdata, if_ready)
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, if_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the fetch PC and sequences one fetch at a time against a
//   variable-latency instruction memory, then hands the word to IF/ID.
//   Redirects (branch > j/jal > jr/jalr) are captured in any cycle; one that
//   arrives while a fetch is in flight is buffered and used for the next PC.
// Ports
//   clk, reset           clock, async active-high reset
//   br_/j_/jr_take,target redirect requests from D
//   bus (master)         imem request/ack channel and IF/ID valid/ready channel
//   addr_err             sticky: misaligned redirect target seen
//   imem_timeout         sticky: a fetch waited TIMEOUT cycles
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_take,
    input  logic [31:0]          br_target,
    input  logic                 j_take,
    input  logic [31:0]          j_target,
    input  logic                 jr_take,
    input  logic [31:0]          jr_target,
    fetch_sequencer_if.master    bus,
    output logic                 addr_err,
    output logic                 imem_timeout
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

    logic [1:0]    state;
    logic [31:0]   pc;
    logic [31:0]   pend_target;
    logic          pending;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   instr_q;
    logic [31:0]   ifpc_q;

    logic          redir_take;
    logic [31:0]   redir_raw;
    logic [31:0]   redir_tgt;
    logic          handoff;
    logic [31:0]   next_pc;

    assign redir_take = br_take | j_take | jr_take;
    assign redir_raw  = br_take ? br_target : (j_take ? j_target : jr_target);
    assign redir_tgt  = {redir_raw[31:2], 2'b00};
    assign handoff    = (state == S_HOLD) && bus.if_ready;
    // A redirect in the handoff cycle is newer than anything buffered.
    assign next_pc    = redir_take ? redir_tgt :
                        (pending ? pend_target : pc + 32'd4);

    // Request/valid decode from state only, so reset drops imem_req at once.
    assign bus.imem_req  = (state == S_REQ);
    assign bus.imem_addr = pc;
    assign bus.if_valid  = (state == S_HOLD);
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ifpc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            pend_target  <= 32'd0;
            pending      <= 1'b0;
            wait_cnt     <= '0;
            instr_q      <= 32'd0;
            ifpc_q       <= 32'd0;
            addr_err     <= 1'b0;
            imem_timeout <= 1'b0;
        end else begin
            if (redir_take && (redir_raw[1:0] != 2'b00))
                addr_err <= 1'b1;

            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (bus.imem_ack) begin
                        instr_q  <= bus.imem_rdata;
                        ifpc_q   <= pc;
                        wait_cnt <= '0;
                        state    <= S_HOLD;
                    end else begin
                        if (wait_cnt != CNT_MAX)
                            wait_cnt <= wait_cnt + 1'b1;
                        // Flag on the edge where the count reaches TIMEOUT.
                        if (wait_cnt >= CNT_MAX - 1'b1)
                            imem_timeout <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.if_ready) begin
                        pc      <= next_pc;
                        pending <= 1'b0;
                        state   <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Buffer a redirect not consumed directly; newest one wins.
            if (redir_take && !handoff) begin
                pending     <= 1'b1;
                pend_target <= redir_tgt;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_take = 1'b0, j_take = 1'b0, jr_take = 1'b0;
    logic [31:0] br_target = '0, j_target = '0, jr_target = '0;
    logic        addr_err, imem_timeout;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .br_take(br_take), .br_target(br_target),
        .j_take(j_take), .j_target(j_target),
        .jr_take(jr_take), .jr_target(jr_target),
        .bus(bus),
        .addr_err(addr_err), .imem_timeout(imem_timeout)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: transaction-level view of the fetch stream.
    bit          m_boot, m_req, m_valid, m_redir, m_err, m_tmo;
    logic [31:0] m_addr, m_rtgt, m_instr, m_ifpc;
    int          m_waits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_req = 0; m_valid = 0; m_redir = 0; m_err = 0; m_tmo = 0;
        m_addr = RESET_PC; m_rtgt = '0; m_instr = '0; m_ifpc = '0; m_waits = 0;
    endtask

    task automatic clear_redir();
        br_take = 0; j_take = 0; jr_take = 0;
    endtask

    // Called at a negedge: check outputs, advance model over the next edge.
    task automatic step();
        logic [31:0] t;
        bit          tk;
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req});
        chk("imem_addr", bus.imem_addr, m_addr);
        chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
        chk("if_instr", bus.if_instr, m_instr);
        chk("if_pc", bus.if_pc, m_ifpc);
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
        chk("imem_timeout", {31'd0, imem_timeout}, {31'd0, m_tmo});
        bus.imem_rdata = $urandom();
        tk = br_take | j_take | jr_take;
        t  = br_take ? br_target : (j_take ? j_target : jr_target);
        if (tk && t[1:0] != 2'b00) m_err = 1;
        t = t & ~32'd3;
        if (m_boot) begin
            m_boot = 0; m_req = 1;
        end else if (m_req) begin
            if (bus.imem_ack) begin
                m_instr = bus.imem_rdata; m_ifpc = m_addr;
                m_req = 0; m_valid = 1; m_waits = 0;
            end else begin
                if (m_waits < TIMEOUT) m_waits++;
                if (m_waits >= TIMEOUT) m_tmo = 1;
            end
        end else if (m_valid && bus.if_ready) begin
            m_addr  = tk ? t : (m_redir ? m_rtgt : m_addr + 32'd4);
            m_redir = 0; tk = 0;
            m_valid = 0; m_req = 1;
        end
        if (tk) begin m_redir = 1; m_rtgt = t; end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_flags", {30'd0, addr_err, imem_timeout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.imem_ack = 0;
        reset = 0;
    endtask

    task automatic run_until_req(input logic [31:0] addr, input int budget);
        int k = 0;
        while (!(m_req && m_addr == addr) && k < budget) begin step(); k++; end
        chk("reach_req_addr", bus.imem_addr, addr);
        chk("reach_req", {31'd0, bus.imem_req}, 32'd1);
    endtask

    task automatic run_until_valid(input int budget);
        int k = 0;
        while (!m_valid && k < budget) begin step(); k++; end
        chk("reach_valid", {31'd0, bus.if_valid}, 32'd1);
    endtask

    initial begin
        bus.imem_ack = 0; bus.imem_rdata = '0; bus.if_ready = 0;
        @(negedge clk);
        do_reset();

        // Sequential fetch, one bubble after reset release.
        bus.imem_ack = 1; bus.if_ready = 1;
        chk("bubble_no_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        chk("first_req", bus.imem_addr, 32'h3000);
        run_until_req(32'h3004, 6);
        // Branch and jump together in S_REQ: branch wins, 0x3004 still delivered.
        br_take = 1; br_target = 32'h3100; j_take = 1; j_target = 32'h3200;
        step();
        clear_redir();
        chk("delay_slot_pc", bus.if_pc, 32'h3004);
        step();
        chk("branch_fetch", bus.imem_addr, 32'h3100);

        // IF/ID stall for 5 cycles.
        bus.if_ready = 0;
        run_until_valid(4);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
        end
        // Misaligned jr target while held.
        jr_take = 1; jr_target = 32'h3102;
        step();
        clear_redir();
        chk("addr_err_set", {31'd0, addr_err}, 32'd1);
        bus.if_ready = 1;
        step();
        chk("misalign_fetch", bus.imem_addr, 32'h3100);
        for (int i = 0; i < 4; i++) step();
        chk("addr_err_sticky", {31'd0, addr_err}, 32'd1);

        // PC wrap from the top of the address space.
        run_until_valid(4);
        bus.if_ready = 0;
        j_take = 1; j_target = 32'hFFFF_FFFC;
        step();
        clear_redir();
        bus.if_ready = 1;
        run_until_req(32'hFFFF_FFFC, 4);
        run_until_req(32'h0000_0000, 4);

        // Withheld ack: timeout at 16 wait cycles, late ack still completes.
        bus.imem_ack = 0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("timeout_early", {31'd0, imem_timeout}, 32'd0);
        step();
        chk("timeout_set", {31'd0, imem_timeout}, 32'd1);
        bus.imem_ack = 1;
        step();
        chk("late_ack_done", {31'd0, bus.if_valid}, 32'd1);
        chk("late_ack_pc", bus.if_pc, 32'h0000_0000);

        // Reset during an outstanding request.
        bus.if_ready = 1;
        bus.imem_ack = 0;
        step();
        chk("pre_reset_req", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_ack = 1;
        do_reset();
        bus.imem_ack = 1;
        step();
        chk("post_reset_fetch", bus.imem_addr, 32'h3000);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            bus.imem_ack = ($urandom_range(0, 1) == 1);
            bus.if_ready = ($urandom_range(0, 9) < 7);
            br_take = ($urandom_range(0, 9) == 0);
            j_take  = ($urandom_range(0, 9) == 0);
            jr_take = ($urandom_range(0, 9) == 0);
            br_target = $urandom() & ~32'd3;
            j_target  = $urandom() & ~32'd3;
            jr_target = ($urandom_range(0, 15) == 0) ? $urandom() : ($urandom() & ~32'd3);
            step();
        end
        clear_redir();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
